// File: rtl/ysyx_22050499_trap_ctrl.sv
// Trap sequencer and CSR write-port arbiter: turns ecall/mret requests into ordered
// CSR read/write sequences followed by a PC redirect; idles as a datapath passthrough.
module ysyx_22050499_trap_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  trap_valid,
    input  logic [31:0]           trap_pc,
    input  logic [DATA_WIDTH-1:0] trap_cause,
    input  logic                  mret_valid,
    output logic                  req_ready,
    input  logic                  sw_wen,
    input  logic [2:0]            sw_waddr,
    input  logic [DATA_WIDTH-1:0] sw_wdata,
    input  logic [2:0]            sw_raddr,
    output logic [DATA_WIDTH-1:0] sw_rdata,
    output logic                  sw_ready,
    output logic                  csr_wen,
    output logic [2:0]            csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [2:0]            csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ready,
    output logic                  busy
);

    localparam logic [2:0] ADDR_MTVEC   = 3'd1;
    localparam logic [2:0] ADDR_MEPC    = 3'd2;
    localparam logic [2:0] ADDR_MCAUSE  = 3'd3;
    localparam logic [2:0] ADDR_MSTATUS = 3'd4;

    localparam logic [DATA_WIDTH-1:0] TRAP_CLR    = DATA_WIDTH'(32'h0000_1888);
    localparam logic [DATA_WIDTH-1:0] MRET_CLR    = DATA_WIDTH'(32'h0000_0088);
    localparam logic [DATA_WIDTH-1:0] MPIE_SET    = DATA_WIDTH'(32'h0000_0080);
    localparam logic [DATA_WIDTH-1:0] MPP_MACHINE = DATA_WIDTH'(32'h0000_1800);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STAT,
        RD_TVEC,
        RD_EPC,
        R_STAT,
        REDIR
    } state_t;

    state_t                  state;
    logic [31:0]             pc_q;
    logic [DATA_WIDTH-1:0]   cause_q;
    logic [31:0]             target;
    logic [31:0]             aligned_rdata;
    logic [DATA_WIDTH-1:0]   trap_stat;
    logic [DATA_WIDTH-1:0]   mret_stat;

    assign aligned_rdata = {csr_rdata[31:2], 2'b00};

    // MPIE<-MIE, MIE<-0, MPP<-M on trap entry; the reverse shuffle on mret.
    assign trap_stat = (csr_rdata & ~TRAP_CLR) | (DATA_WIDTH'(csr_rdata[3]) << 7) | MPP_MACHINE;
    assign mret_stat = (csr_rdata & ~MRET_CLR) | (DATA_WIDTH'(csr_rdata[7]) << 3)
                     | MPIE_SET | MPP_MACHINE;

    assign busy        = (state != IDLE);
    assign req_ready   = (state == IDLE);
    assign sw_ready    = (state == IDLE);
    assign sw_rdata    = csr_rdata;
    assign redirect_pc = target;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pc_q           <= '0;
            cause_q        <= '0;
            target         <= '0;
            redirect_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        pc_q    <= trap_pc;
                        cause_q <= trap_cause;
                        state   <= W_EPC;
                    end else if (mret_valid) begin
                        state <= RD_EPC;
                    end
                end
                W_EPC:   state <= W_CAUSE;
                W_CAUSE: state <= W_STAT;
                W_STAT:  state <= RD_TVEC;
                RD_TVEC: begin
                    target         <= aligned_rdata;
                    redirect_valid <= 1'b1;
                    state          <= REDIR;
                end
                RD_EPC: begin
                    target <= aligned_rdata;
                    state  <= R_STAT;
                end
                R_STAT: begin
                    redirect_valid <= 1'b1;
                    state          <= REDIR;
                end
                REDIR: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The datapath owns the CSR ports only while idle; sequences own them otherwise.
    always_comb begin
        csr_wen   = 1'b0;
        csr_waddr = 3'd0;
        csr_wdata = '0;
        csr_raddr = 3'd0;
        case (state)
            IDLE: begin
                csr_wen   = sw_wen;
                csr_waddr = sw_waddr;
                csr_wdata = sw_wdata;
                csr_raddr = sw_raddr;
            end
            W_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = DATA_WIDTH'(pc_q);
            end
            W_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = cause_q;
            end
            W_STAT: begin
                csr_raddr = ADDR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = trap_stat;
            end
            RD_TVEC: csr_raddr = ADDR_MTVEC;
            RD_EPC:  csr_raddr = ADDR_MEPC;
            R_STAT: begin
                csr_raddr = ADDR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = mret_stat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050499_trap_ctrl.sv
// Bench for the trap sequencer: a small CSR file sits behind the DUT and a field-level
// model predicts every CSR write (with its cycle) and every redirect target.
module tb_ysyx_22050499_trap_ctrl;

    logic        clock;
    logic        reset;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_valid;
    logic        req_ready;
    logic        sw_wen;
    logic [2:0]  sw_waddr;
    logic [31:0] sw_wdata;
    logic [2:0]  sw_raddr;
    logic [31:0] sw_rdata;
    logic        sw_ready;
    logic        csr_wen;
    logic [2:0]  csr_waddr;
    logic [31:0] csr_wdata;
    logic [2:0]  csr_raddr;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] csrMem [0:7];
    logic [31:0] expCsr [1:4];
    wr_t         writeLog[$];
    int          cyc = 0;
    int          checkCount = 0;
    int          passCount = 0;
    int          failCount = 0;

    ysyx_22050499_trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .req_ready(req_ready),
        .sw_wen(sw_wen), .sw_waddr(sw_waddr), .sw_wdata(sw_wdata),
        .sw_raddr(sw_raddr), .sw_rdata(sw_rdata), .sw_ready(sw_ready),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CSR file stand-in: combinational read, one write port, every write logged with its edge.
    assign csr_rdata = csrMem[csr_raddr];
    always @(posedge clock) begin
        if (csr_wen) begin
            csrMem[csr_waddr] <= csr_wdata;
            writeLog.push_back('{cyc, csr_waddr, csr_wdata});
        end
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic swWrite(input logic [2:0] addr, input logic [31:0] data);
        sw_wen   = 1'b1;
        sw_waddr = addr;
        sw_wdata = data;
        #1;
        checkOutput("sw_ready_idle", 32'(sw_ready), 32'd1);
        checkOutput("sw_pass_wen", 32'(csr_wen), 32'd1);
        checkOutput("sw_pass_waddr", 32'(csr_waddr), 32'(addr));
        step();
        sw_wen = 1'b0;
        expCsr[addr] = data;
    endtask

    task automatic hardReset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    // One trap or mret request; the model works on mstatus fields and the expected write list.
    task automatic applyStimulus(input bit doTrap, input bit doMret, input logic [31:0] pc,
                                 input logic [31:0] cause, input int hold, input bit swSame,
                                 input logic [2:0] swAddr, input logic [31:0] swData,
                                 input bit swDuring);
        int          c;
        int          logStart;
        int          expLat;
        int          n;
        wr_t         expQ[$];
        logic [31:0] expTarget;
        logic [31:0] oldStat;
        logic [31:0] newStat;
        logic [31:0] heldPc;

        c        = cyc;
        logStart = writeLog.size();
        if (swSame) begin
            expQ.push_back('{c, swAddr, swData});
            expCsr[swAddr] = swData;
        end
        oldStat = expCsr[4];
        newStat = oldStat;
        newStat[12:11] = 2'b11;
        if (doTrap) begin
            expQ.push_back('{c + 1, 3'd2, pc});
            expCsr[2] = pc;
            expQ.push_back('{c + 2, 3'd3, cause});
            expCsr[3] = cause;
            newStat[7] = oldStat[3];
            newStat[3] = 1'b0;
            expQ.push_back('{c + 3, 3'd4, newStat});
            expTarget = (expCsr[1] >> 2) << 2;
            expLat = 5;
        end else begin
            expTarget = (expCsr[2] >> 2) << 2;
            newStat[3] = oldStat[7];
            newStat[7] = 1'b1;
            expQ.push_back('{c + 2, 3'd4, newStat});
            expLat = 3;
        end
        expCsr[4] = newStat;

        trap_valid     = doTrap;
        trap_pc        = pc;
        trap_cause     = cause;
        mret_valid     = doMret;
        sw_wen         = swSame;
        sw_waddr       = swAddr;
        sw_wdata       = swData;
        redirect_ready = (hold == 0);
        #1;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        step();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        sw_wen     = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);

        if (swDuring) begin
            step();
            sw_wen   = 1'b1;
            sw_waddr = 3'd1;
            sw_wdata = $urandom;
            #1;
            checkOutput("sw_ready_busy", 32'(sw_ready), 32'd0);
            if (doTrap) begin
                checkOutput("wcause_waddr", 32'(csr_waddr), 32'd3);
                checkOutput("wcause_raddr", 32'(csr_raddr), 32'd0);
            end
        end

        while (redirect_valid !== 1'b1 && (cyc - c) < 20) begin
            step();
            sw_wen = 1'b0;
        end
        checkOutput("redirect_latency", 32'(cyc - c), 32'(expLat));
        if (redirect_valid !== 1'b1) begin
            $display("[TB] redirect never arrived, resetting");
            hardReset();
            return;
        end
        checkOutput("redirect_pc", redirect_pc, expTarget);
        heldPc = redirect_pc;

        for (int i = 0; i < hold; i++) begin
            step();
            checkOutput("hold_valid", 32'(redirect_valid), 32'd1);
            checkOutput("hold_pc", redirect_pc, heldPc);
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        checkOutput("idle_after_redirect", 32'(busy), 32'd0);
        checkOutput("valid_dropped", 32'(redirect_valid), 32'd0);

        n = writeLog.size() - logStart;
        checkOutput("write_count", 32'(n), 32'(expQ.size()));
        for (int i = 0; i < n && i < expQ.size(); i++) begin
            checkOutput("write_cycle", 32'(writeLog[logStart + i].cyc - c),
                        32'(expQ[i].cyc - c));
            checkOutput("write_addr", 32'(writeLog[logStart + i].addr), 32'(expQ[i].addr));
            checkOutput("write_data", writeLog[logStart + i].data, expQ[i].data);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int logStart;

        reset = 1'b0;
        trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; mret_valid = 1'b0;
        sw_wen = 1'b0; sw_waddr = '0; sw_wdata = '0; sw_raddr = '0;
        redirect_ready = 1'b0;

        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_sw_ready", 32'(sw_ready), 32'd1);
        checkOutput("reset_redirect_valid", 32'(redirect_valid), 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
        sw_wen = 1'b1; sw_waddr = 3'd1;
        #1;
        checkOutput("reset_csr_wen_follows", 32'(csr_wen), 32'd1);
        sw_wen = 1'b0;
        #1;
        checkOutput("reset_csr_wen_low", 32'(csr_wen), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        $display("[TB] ecall");
        swWrite(3'd4, 32'h0000_0008);
        swWrite(3'd1, 32'h8000_0101);
        swWrite(3'd2, 32'h0);
        swWrite(3'd3, 32'h0);
        sw_raddr = 3'd1;
        #1;
        checkOutput("sw_rdata_mtvec", sw_rdata, 32'h8000_0101);
        checkOutput("idle_raddr_pass", 32'(csr_raddr), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h8000_0040, 32'd11, 0, 1'b0, 3'd1, 32'h0, 1'b0);
        checkOutput("ecall_mstatus", expCsr[4], 32'h0000_1880);

        $display("[TB] mret");
        swWrite(3'd2, 32'h8000_0044);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b0, 3'd1, 32'h0, 1'b0);
        checkOutput("mret_mstatus", expCsr[4], 32'h0000_1888);

        $display("[TB] simultaneous trap, mret and sw write");
        applyStimulus(1'b1, 1'b1, 32'h8000_0050, 32'd11, 0, 1'b1, 3'd1, 32'h8000_0200, 1'b0);

        $display("[TB] sw write during W_CAUSE");
        applyStimulus(1'b1, 1'b0, 32'h8000_0060, 32'd3, 0, 1'b0, 3'd1, 32'h0, 1'b1);

        $display("[TB] redirect backpressure");
        applyStimulus(1'b1, 1'b0, 32'h8000_0070, 32'd2, 4, 1'b0, 3'd1, 32'h0, 1'b0);

        $display("[TB] reset mid W_CAUSE");
        logStart = writeLog.size();
        trap_valid = 1'b1; trap_pc = 32'h8000_0080; trap_cause = 32'd7;
        step();
        trap_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_redirect_valid", 32'(redirect_valid), 32'd0);
        checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midreset_redirect_pc", redirect_pc, 32'd0);
        step();
        step();
        checkOutput("midreset_writes", 32'(writeLog.size() - logStart), 32'd1);
        expCsr[2] = 32'h8000_0080;
        reset = 1'b1;
        step();
        applyStimulus(1'b1, 1'b0, 32'h8000_0090, 32'd11, 1, 1'b0, 3'd1, 32'h0, 1'b0);

        $display("[TB] randomized requests");
        for (int k = 0; k < 25; k++) begin
            bit          t;
            bit          m;
            logic [31:0] pcv;
            if ($urandom_range(0, 2) == 0) swWrite(3'd1, $urandom);
            if ($urandom_range(0, 2) == 0) swWrite(3'd4, $urandom);
            if ($urandom_range(0, 3) == 0) swWrite(3'd2, $urandom);
            t   = 1'($urandom_range(0, 1));
            m   = t ? 1'($urandom_range(0, 1)) : 1'b1;
            pcv = $urandom;
            applyStimulus(t, m, pcv, $urandom, $urandom_range(0, 4),
                          1'($urandom_range(0, 1)), 3'($urandom_range(1, 4)), $urandom,
                          1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
